dhcp_vlg_lease_ctl: RTL and testbench

Sequencer that sits above the DHCP core and drives its start/ready/success/fail control handshake. It acquires an address, tracks the lease in seconds and re-runs DHCP at T1 (half the lease) to renew. On failure it retries with exponential backoff. It publishes the validated local IPv4 address to the rest of the stack and withdraws it when the lease expires or the controller is disabled.

---
 rtl/dhcp_vlg_lease_ctl_if.sv | 39 +++
 rtl/dhcp_vlg_lease_ctl.sv | 163 ++++++++++++++++
 tb/tb_dhcp_vlg_lease_ctl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dhcp_vlg_lease_ctl_if.sv
// dhcp_vlg_lease_ctl_if
// ---------------------
// Control handshake between the lease controller and the DHCP core.
//
// Handshake: the controller (master) raises dhcp_start for exactly one clock
// to launch a run. The core (slave) answers with dhcp_ready held high as a
// level, together with exactly one of dhcp_success / dhcp_fail. While
// dhcp_success is high, dhcp_assig_ip, lease_s and lease_val are valid.
// dhcp_ready may remain high for up to three cycles after a new start pulse
// (left over from the previous run). A response therefore only counts after
// the controller has seen dhcp_ready low at least once since its start pulse.
//
// Signals:
//   dhcp_start     master -> slave  one-cycle start pulse
//   dhcp_ready     slave -> master  run finished (success OR fail)
//   dhcp_success   slave -> master  run finished with an ACK
//   dhcp_fail      slave -> master  run finished without an address
//   dhcp_assig_ip  slave -> master  assigned IPv4 address
//   lease_s        slave -> master  lease time in seconds from the ACK
//   lease_val      slave -> master  lease_s present in the ACK
interface dhcp_vlg_lease_ctl_if;
  logic        dhcp_start;
  logic        dhcp_ready;
  logic        dhcp_success;
  logic        dhcp_fail;
  logic [31:0] dhcp_assig_ip;
  logic [31:0] lease_s;
  logic        lease_val;

  modport master (
    output dhcp_start,
    input  dhcp_ready, dhcp_success, dhcp_fail, dhcp_assig_ip, lease_s, lease_val
  );

  modport slave (
    input  dhcp_start,
    output dhcp_ready, dhcp_success, dhcp_fail, dhcp_assig_ip, lease_s, lease_val
  );
endinterface

// File: rtl/dhcp_vlg_lease_ctl.sv
// dhcp_vlg_lease_ctl
// ------------------
// Lease sequencer above the DHCP core. Acquires an address, counts the lease
// down in seconds, re-runs DHCP at T1 (half the lease) to renew, and retries
// failed runs with an exponential backoff. The validated address is published
// on ip/ip_val and withdrawn on expiry or when en drops.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   en         1 = acquire and maintain an address, 0 = release
//   dhcp       master side of the DHCP core handshake
//   ip         current local IPv4 address
//   ip_val     ip is usable (lease not expired)
//   state      FSM state: IDLE=0, START=1, WAIT=2, BOUND=3, BACKOFF=4
//   renew_cnt  successful acquisitions/renewals, saturating
//   fail_cnt   DHCP failures, saturating
module dhcp_vlg_lease_ctl #(
  parameter int unsigned TICKS_PER_SEC   = 125000000,
  parameter int unsigned DEFAULT_LEASE_S = 3600,
  parameter int unsigned MIN_LEASE_S     = 60,
  parameter int unsigned RETRY_BACKOFF_S = 4,
  parameter int unsigned MAX_BACKOFF_S   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  dhcp_vlg_lease_ctl_if.master        dhcp,
  output logic [31:0]                 ip,
  output logic                        ip_val,
  output logic [2:0]                  state,
  output logic [15:0]                 renew_cnt,
  output logic [7:0]                  fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_BOUND   = 3'd3,
    S_BACKOFF = 3'd4
  } state_t;

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  state_t      st;
  logic [PW-1:0] presc;
  logic [31:0] lease_rem;
  logic [31:0] t1_rem;
  logic [31:0] backoff;
  logic        armed;   // seen dhcp_ready low since the last start pulse

  logic        sec_tick;
  logic [31:0] lease_dec;
  logic [31:0] t1_dec;
  logic [31:0] lease_l;
  logic [32:0] backoff_x2;
  logic [31:0] backoff_nxt;
  logic        rsp_live;
  logic        got_ack;
  logic        got_nak;

  assign state = st;

  // Prescaler is held at 0 in IDLE, so no tick can fire there.
  assign sec_tick = (st != S_IDLE) && (presc == PRESC_MAX);

  always_comb begin
    lease_dec = lease_rem;
    t1_dec    = t1_rem;
    if (sec_tick && (lease_rem != 32'd0)) lease_dec = lease_rem - 32'd1;
    if (sec_tick && (t1_rem != 32'd0))    t1_dec    = t1_rem - 32'd1;
  end

  // Lease to load from an ACK: floor-clamped when present, default otherwise.
  always_comb begin
    lease_l = 32'(DEFAULT_LEASE_S);
    if (dhcp.lease_val)
      lease_l = (dhcp.lease_s < 32'(MIN_LEASE_S)) ? 32'(MIN_LEASE_S) : dhcp.lease_s;
  end

  // Doubling is done one bit wider so a large backoff cannot wrap below the cap.
  assign backoff_x2  = {backoff, 1'b0};
  assign backoff_nxt = (backoff_x2 > 33'(MAX_BACKOFF_S)) ? 32'(MAX_BACKOFF_S)
                                                         : backoff_x2[31:0];

  assign rsp_live = (st == S_WAIT) && armed && dhcp.dhcp_ready;
  assign got_ack  = rsp_live && dhcp.dhcp_success;
  assign got_nak  = rsp_live && !dhcp.dhcp_success && dhcp.dhcp_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st              <= S_IDLE;
      dhcp.dhcp_start <= 1'b0;
      ip              <= 32'd0;
      ip_val          <= 1'b0;
      renew_cnt       <= 16'd0;
      fail_cnt        <= 8'd0;
      lease_rem       <= 32'd0;
      t1_rem          <= 32'd0;
      backoff         <= 32'(RETRY_BACKOFF_S);
      presc           <= '0;
      armed           <= 1'b0;
    end else if (!en) begin
      // Release wins over everything; an in-flight run is abandoned.
      st              <= S_IDLE;
      dhcp.dhcp_start <= 1'b0;
      ip              <= 32'd0;
      ip_val          <= 1'b0;
      lease_rem       <= 32'd0;
      backoff         <= 32'(RETRY_BACKOFF_S);
      presc           <= '0;
      armed           <= 1'b0;
    end else begin
      dhcp.dhcp_start <= 1'b0;
      presc     <= ((st == S_IDLE) || (presc == PRESC_MAX)) ? '0 : presc + PW'(1);
      lease_rem <= lease_dec;
      t1_rem    <= t1_dec;
      // Tracks the next lease value so ip_val falls together with lease_rem.
      ip_val    <= (lease_dec != 32'd0);

      case (st)
        S_IDLE: begin
          // dhcp_start is registered on entry so it is high exactly in START.
          st              <= S_START;
          dhcp.dhcp_start <= 1'b1;
        end
        S_START: begin
          armed <= 1'b0;
          st    <= S_WAIT;
        end
        S_WAIT: begin
          if (!dhcp.dhcp_ready) armed <= 1'b1;
          if (got_ack) begin
            // Load overrides any decrement from a tick in this cycle.
            ip        <= dhcp.dhcp_assig_ip;
            lease_rem <= lease_l;
            t1_rem    <= lease_l >> 1;
            ip_val    <= (lease_l != 32'd0);
            backoff   <= 32'(RETRY_BACKOFF_S);
            if (renew_cnt != 16'hFFFF) renew_cnt <= renew_cnt + 16'd1;
            st        <= S_BOUND;
          end else if (got_nak) begin
            if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            t1_rem  <= backoff;
            backoff <= backoff_nxt;
            st      <= S_BACKOFF;
          end
        end
        S_BOUND, S_BACKOFF: begin
          // t1_rem doubles as renewal timer (BOUND) and retry timer (BACKOFF).
          if (t1_rem == 32'd0) begin
            st              <= S_START;
            dhcp.dhcp_start <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dhcp_vlg_lease_ctl.sv
// tb_dhcp_vlg_lease_ctl
// ---------------------
// Bench for dhcp_vlg_lease_ctl with a one-second prescale of 10 cycles.
// A table of DHCP runs (directed rows followed by random rows) is played
// through a mock core; start-pulse timing, lease expiry and outputs are
// predicted from the lease/backoff rules and the tick grid.
module tb_dhcp_vlg_lease_ctl;
  localparam int TPS    = 10;
  localparam int MIN_L  = 60;
  localparam int DEF_L  = 3600;
  localparam int BO0    = 4;
  localparam int BO_MAX = 64;
  localparam int NDIR   = 15;
  localparam int NROWS  = 35;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] ip;
  logic        ip_val;
  logic [2:0]  state;
  logic [15:0] renew_cnt;
  logic [7:0]  fail_cnt;

  dhcp_vlg_lease_ctl_if bus();

  dhcp_vlg_lease_ctl #(
    .TICKS_PER_SEC(TPS), .DEFAULT_LEASE_S(DEF_L), .MIN_LEASE_S(MIN_L),
    .RETRY_BACKOFF_S(BO0), .MAX_BACKOFF_S(BO_MAX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dhcp(bus),
    .ip(ip), .ip_val(ip_val), .state(state),
    .renew_cnt(renew_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse-shape and ip_val-fall monitor, sampled on the falling edge.
  logic prev_start  = 1'b0;
  logic prev_ipval  = 1'b0;
  int   fall_cyc    = -1;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dhcp_start) begin
        total++;
        if (prev_start || state != 3'd1) begin
          bad++;
          $display("FAIL start_pulse: prev=%0b state=%0d expected single pulse in state 1 (cycle %0d)",
                   prev_start, state, cyc);
        end
      end
      if (prev_ipval && !ip_val) fall_cyc = cyc;
    end
    prev_start = bus.dhcp_start;
    prev_ipval = ip_val;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int pred, output int s);
    while (!bus.dhcp_start && cyc < pred + 20) step();
    s = bus.dhcp_start ? cyc : -1;
  endtask

  task automatic core_idle();
    bus.dhcp_ready   = 1'b0;
    bus.dhcp_success = 1'b0;
    bus.dhcp_fail    = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int base;          // first START cycle after leaving IDLE (prescaler phase 0)
  int expiry   = 0;  // first cycle in which ip_val must read 0
  bit exp_pending = 1'b0;

  // Cycle of the n-th one-second tick at or after cycle c.
  function automatic int nth_tick(input int c, input int n);
    int r;
    r = (c - base) % TPS;
    return c + (TPS - 1 - r) + (n - 1) * TPS;
  endfunction

  function automatic int model_lease(input bit lv, input int ls);
    if (!lv) return DEF_L;
    return (ls < MIN_L) ? MIN_L : ls;
  endfunction

  task automatic check_expiry(input int now);
    if (exp_pending && now > expiry) begin
      check("ipval_fall_cycle", 32'(fall_cyc), 32'(expiry));
      exp_pending = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          dly;    // cycles from start pulse to response
    bit          succ;
    bit          both;   // fail raised together with success
    bit          lv;
    int          ls;
    logic [31:0] ipa;
    int          stale;  // cycles the previous response lingers after start
    int          exp_l;  // expected lease (success rows)
    int          exp_bo; // expected retry delay (fail rows)
  } row_t;

  row_t tbl[NROWS];

  initial begin
    int pred, s, e, m_renew, m_fail, bo;
    logic [31:0] m_ip;

    core_idle();
    bus.dhcp_assig_ip = 32'd0;
    bus.lease_s       = 32'd0;
    bus.lease_val     = 1'b0;

    tbl[0]  = '{20, 1'b1, 1'b0, 1'b1, 100, 32'hC0A80164, 0, 100, 0};
    tbl[1]  = '{5,  1'b1, 1'b0, 1'b1, 10,  32'hC0A80165, 3, 60,  0};
    tbl[2]  = '{7,  1'b0, 1'b0, 1'b0, 0,   32'h0,        2, 0,   4};
    tbl[3]  = '{4,  1'b0, 1'b0, 1'b0, 0,   32'h0,        1, 0,   8};
    tbl[4]  = '{3,  1'b0, 1'b0, 1'b0, 0,   32'h0,        0, 0,   16};
    tbl[5]  = '{6,  1'b0, 1'b0, 1'b0, 0,   32'h0,        3, 0,   32};
    tbl[6]  = '{3,  1'b1, 1'b0, 1'b0, 500, 32'h0A000005, 0, 3600, 0};
    tbl[7]  = '{4,  1'b1, 1'b0, 1'b1, 200, 32'h0A000006, 2, 200, 0};
    tbl[8]  = '{5,  1'b0, 1'b0, 1'b0, 0,   32'h0,        3, 0,   4};
    tbl[9]  = '{2,  1'b0, 1'b0, 1'b0, 0,   32'h0,        0, 0,   8};
    tbl[10] = '{9,  1'b0, 1'b0, 1'b0, 0,   32'h0,        1, 0,   16};
    tbl[11] = '{4,  1'b0, 1'b0, 1'b0, 0,   32'h0,        2, 0,   32};
    tbl[12] = '{6,  1'b0, 1'b0, 1'b0, 0,   32'h0,        3, 0,   64};
    tbl[13] = '{3,  1'b0, 1'b0, 1'b0, 0,   32'h0,        0, 0,   64};
    tbl[14] = '{5,  1'b1, 1'b1, 1'b1, 61,  32'hC0A80001, 1, 61,  0};
    bo = BO0;
    for (int i = NDIR; i < NROWS; i++) begin
      tbl[i].stale  = $urandom_range(0, 3);
      tbl[i].dly    = $urandom_range(tbl[i].stale + 2, 25);
      tbl[i].succ   = 1'($urandom_range(0, 1));
      tbl[i].both   = tbl[i].succ && ($urandom_range(0, 1) == 1);
      tbl[i].lv     = 1'b1;
      tbl[i].ls     = $urandom_range(0, 150);
      tbl[i].ipa    = $urandom;
      tbl[i].exp_l  = tbl[i].succ ? model_lease(tbl[i].lv, tbl[i].ls) : 0;
      tbl[i].exp_bo = tbl[i].succ ? 0 : bo;
      bo = tbl[i].succ ? BO0 : ((2 * bo > BO_MAX) ? BO_MAX : 2 * bo);
    end

    // ---- reset values ----
    step(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ip", ip, 32'd0);
    check("rst_ipval", 32'(ip_val), 32'd0);
    check("rst_renew", 32'(renew_cnt), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    check("rst_start", 32'(bus.dhcp_start), 32'd0);
    rst = 1'b0;
    step(4);
    check("idle_disabled", 32'(state), 32'd0);

    // ---- table-driven runs ----
    m_renew = 0;
    m_fail  = 0;
    m_ip    = 32'd0;
    en      = 1'b1;
    pred    = cyc + 1;
    base    = pred;
    for (int i = 0; i < NROWS; i++) begin
      row_t r;
      r = tbl[i];
      wait_start(pred, s);
      check($sformatf("row%0d_start_cycle", i), 32'(s), 32'(pred));
      if (s < 0) break;
      check_expiry(s);
      check($sformatf("row%0d_ipval_at_start", i), 32'(ip_val), 32'(s < expiry));
      for (int k = 0; k < r.stale; k++) begin
        step();
        check($sformatf("row%0d_stale_state", i), 32'(state), 32'd2);
        check($sformatf("row%0d_stale_renew", i), 32'(renew_cnt), 32'(m_renew));
        check($sformatf("row%0d_stale_fail", i), 32'(fail_cnt), 32'(m_fail));
      end
      core_idle();
      step(r.dly - r.stale);
      bus.dhcp_ready    = 1'b1;
      bus.dhcp_success  = r.succ;
      bus.dhcp_fail     = !r.succ || r.both;
      bus.dhcp_assig_ip = r.succ ? r.ipa : 32'hDEADBEEF;
      bus.lease_s       = 32'(r.ls);
      bus.lease_val     = r.lv;
      step();
      e = cyc;
      check_expiry(e);
      if (r.succ) begin
        m_renew++;
        m_ip        = r.ipa;
        expiry      = nth_tick(e, r.exp_l) + 1;
        exp_pending = 1'b1;
        pred        = nth_tick(e, r.exp_l >> 1) + 2;
        check($sformatf("row%0d_state", i), 32'(state), 32'd3);
        check($sformatf("row%0d_ipval", i), 32'(ip_val), 32'd1);
      end else begin
        m_fail++;
        pred = nth_tick(e, r.exp_bo) + 2;
        check($sformatf("row%0d_state", i), 32'(state), 32'd4);
        check($sformatf("row%0d_ipval", i), 32'(ip_val), 32'(e < expiry));
      end
      check($sformatf("row%0d_ip", i), ip, m_ip);
      check($sformatf("row%0d_renew", i), 32'(renew_cnt), 32'(m_renew));
      check($sformatf("row%0d_fail", i), 32'(fail_cnt), 32'(m_fail));
    end

    // ---- en=0 while in WAIT, later response ignored ----
    wait_start(pred, s);
    check("dis_start_cycle", 32'(s), 32'(pred));
    core_idle();
    step(3);
    check("dis_in_wait", 32'(state), 32'd2);
    en = 1'b0;
    step();
    check("dis_state", 32'(state), 32'd0);
    check("dis_ipval", 32'(ip_val), 32'd0);
    check("dis_ip", ip, 32'd0);
    check("dis_renew_kept", 32'(renew_cnt), 32'(m_renew));
    check("dis_fail_kept", 32'(fail_cnt), 32'(m_fail));
    exp_pending = 1'b0;
    bus.dhcp_ready    = 1'b1;
    bus.dhcp_success  = 1'b1;
    bus.dhcp_assig_ip = 32'h01020304;
    step(6);
    check("dis_late_state", 32'(state), 32'd0);
    check("dis_late_renew", 32'(renew_cnt), 32'(m_renew));
    check("dis_late_ip", ip, 32'd0);

    // ---- re-acquire, then async reset off a clock edge mid-BOUND ----
    core_idle();
    step();
    en   = 1'b1;
    pred = cyc + 1;
    base = pred;
    wait_start(pred, s);
    check("reacq_start_cycle", 32'(s), 32'(pred));
    step(10);
    bus.dhcp_ready    = 1'b1;
    bus.dhcp_success  = 1'b1;
    bus.dhcp_assig_ip = 32'hC0A80164;
    bus.lease_s       = 32'd100;
    bus.lease_val     = 1'b1;
    step();
    check("reacq_state", 32'(state), 32'd3);
    check("reacq_ip", ip, 32'hC0A80164);
    step(37);
    check("pre_rst_bound", 32'(state), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_ip", ip, 32'd0);
    check("arst_ipval", 32'(ip_val), 32'd0);
    check("arst_renew", 32'(renew_cnt), 32'd0);
    check("arst_fail", 32'(fail_cnt), 32'd0);
    check("arst_start", 32'(bus.dhcp_start), 32'd0);

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
